// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding-select pipeline.
// Holds the select encoding, the shadow-slot record and the slot match helper.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 3;

    localparam logic [SEL_W-1:0] SEL_REGFILE = 3'b000;
    localparam logic [SEL_W-1:0] SEL_MEM     = 3'b001;
    localparam logic [SEL_W-1:0] SEL_WB      = 3'b010;
    localparam logic [SEL_W-1:0] SEL_PWB     = 3'b011;
    localparam logic [SEL_W-1:0] SEL_ALT     = 3'b100;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } shadow_t;

    // r0 is hardwired zero, so it never matches a producer
    function automatic logic slot_match(input shadow_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.regwrite & (s.rd == r) & (r != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_sel_pipe_if.sv
// ID-side request and EX-side select bundle of the forwarding-select pipeline.
interface fwd_sel_pipe_if;

    logic                            id_valid;
    logic [fwd_pkg::REG_ADDR_W-1:0]  id_rs;
    logic [fwd_pkg::REG_ADDR_W-1:0]  id_rt;
    logic [fwd_pkg::REG_ADDR_W-1:0]  id_rd;
    logic                            id_regwrite;
    logic                            id_memread;
    logic                            id_use_rs;
    logic                            id_use_rt;
    logic                            id_alusrc;
    logic                            id_link;
    logic                            stall_in;
    logic                            flush_in;
    logic                            ex_valid;
    logic [fwd_pkg::SEL_W-1:0]       fwd_a_sel;
    logic [fwd_pkg::SEL_W-1:0]       fwd_b_sel;
    logic                            load_use_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread,
               id_use_rs, id_use_rt, id_alusrc, id_link, stall_in, flush_in,
        input  ex_valid, fwd_a_sel, fwd_b_sel, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread,
               id_use_rs, id_use_rt, id_alusrc, id_link, stall_in, flush_in,
        output ex_valid, fwd_a_sel, fwd_b_sel, load_use_stall
    );

endinterface

// File: rtl/fwd_match.sv
// Priority encoder: picks the newest in-flight producer of one source register.
// The WB slot is searched only when POST_WB_EN is set.
module fwd_match
    import fwd_pkg::*;
#(
    parameter bit POST_WB_EN = 1'b0
) (
    input  logic [REG_ADDR_W-1:0] i_reg,
    input  shadow_t               i_ex,
    input  shadow_t               i_mem,
    input  shadow_t               i_wb,
    output logic [SEL_W-1:0]      o_sel
);

    // Newest producer first: EX lands in MEM, MEM lands in WB, WB lands in post-WB
    always_comb begin
        o_sel = SEL_REGFILE;
        if (slot_match(i_ex, i_reg)) begin
            o_sel = SEL_MEM;
        end else if (slot_match(i_mem, i_reg)) begin
            o_sel = SEL_WB;
        end else if (POST_WB_EN && slot_match(i_wb, i_reg)) begin
            o_sel = SEL_PWB;
        end else begin
            o_sel = SEL_REGFILE;
        end
    end

endmodule

// File: rtl/fwd_sel_pipe.sv
// Forwarding-select generator: shadows EX/MEM/WB destinations and registers the
// EX operand-mux selects. FWD_POST_WB_EN adds the post-WB slot and select 011.
module fwd_sel_pipe
    import fwd_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fwd_sel_pipe_if.slave  bus
);

`ifdef FWD_POST_WB_EN
    localparam bit POST_WB = 1'b1;
    shadow_t r_pwb;
`else
    localparam bit POST_WB = 1'b0;
`endif

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic [SEL_W-1:0] r_a_sel;
    logic [SEL_W-1:0] r_b_sel;

    logic [SEL_W-1:0] w_a_match;
    logic [SEL_W-1:0] w_b_match;
    logic [SEL_W-1:0] w_a_sel;
    logic [SEL_W-1:0] w_b_sel;
    logic             w_load_use;
    shadow_t          w_ex_next;

    fwd_match #(.POST_WB_EN(POST_WB)) u_match_a (
        .i_reg (bus.id_rs),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (w_a_match)
    );

    fwd_match #(.POST_WB_EN(POST_WB)) u_match_b (
        .i_reg (bus.id_rt),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (w_b_match)
    );

    // A load still in EX cannot forward yet; the consumer waits one bubble
    always_comb begin
        w_load_use = r_ex.valid & r_ex.load & bus.id_valid &
                     ((bus.id_use_rs & slot_match(r_ex, bus.id_rs)) |
                      (bus.id_use_rt & ~bus.id_alusrc & slot_match(r_ex, bus.id_rt)));
    end

    // Operand overrides: link/immediate win, unused operands read the regfile
    always_comb begin
        w_a_sel = SEL_REGFILE;
        w_b_sel = SEL_REGFILE;
        if (bus.id_link) begin
            w_a_sel = SEL_ALT;
        end else if (!bus.id_use_rs) begin
            w_a_sel = SEL_REGFILE;
        end else begin
            w_a_sel = w_a_match;
        end
        if (bus.id_alusrc) begin
            w_b_sel = SEL_ALT;
        end else if (!bus.id_use_rt) begin
            w_b_sel = SEL_REGFILE;
        end else begin
            w_b_sel = w_b_match;
        end
    end

    // Shadow record for the instruction leaving ID
    always_comb begin
        w_ex_next          = '0;
        w_ex_next.valid    = bus.id_valid;
        w_ex_next.regwrite = bus.id_regwrite;
        w_ex_next.load     = bus.id_memread;
        w_ex_next.rd       = bus.id_rd;
    end

    // Shadow pipeline and select registers; a freeze holds everything, flush included
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
`ifdef FWD_POST_WB_EN
            r_pwb   <= '0;
`endif
            r_a_sel <= SEL_REGFILE;
            r_b_sel <= SEL_REGFILE;
        end else if (!bus.stall_in) begin
`ifdef FWD_POST_WB_EN
            r_pwb <= r_wb;
`endif
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (bus.flush_in || w_load_use) begin
                r_ex    <= '0;
                r_a_sel <= SEL_REGFILE;
                r_b_sel <= SEL_REGFILE;
            end else begin
                r_ex    <= w_ex_next;
                r_a_sel <= w_a_sel;
                r_b_sel <= w_b_sel;
            end
        end
    end

    assign bus.ex_valid       = r_ex.valid;
    assign bus.fwd_a_sel      = r_a_sel;
    assign bus.fwd_b_sel      = r_b_sel;
    assign bus.load_use_stall = w_load_use;

endmodule
